// File: rtl/port_rd_outport.sv
// rtl/port_rd_outport.sv - per-port read-side output stage with packet FIFO
// Purpose: buffers packet words from the shared SRAM read path for one egress
//   port and replays them as framed packets under the per-port ready handshake.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_vld/in_data/in_eop  incoming word; in_data of the first word is the header
//                      ([3:0] dest, [6:4] prio, [15:7] payload length)
//   in_pause           registered almost-full backpressure
//   ready              downstream accept, only looked at between packets
//   rd_sop/rd_vld/rd_data/rd_eop  outgoing packet stream
//   pkt_done           pulse with rd_eop
//   ovf                sticky, a word was dropped on a full FIFO
//   len_err            pulse with rd_eop when the payload count disagrees with the header
//   fifo_count         current occupancy
// Optional: RD_LEN_CHECK_EN builds the payload length checker; otherwise len_err is 0.
module port_rd_outport #(
  parameter int FIFO_DEPTH   = 32,
  parameter int AFULL_MARGIN = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_vld,
  input  logic [15:0]                   in_data,
  input  logic                          in_eop,
  output logic                          in_pause,
  input  logic                          ready,
  output logic                          rd_sop,
  output logic                          rd_vld,
  output logic [15:0]                   rd_data,
  output logic                          rd_eop,
  output logic                          pkt_done,
  output logic                          ovf,
  output logic                          len_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PAUSE_LVL = PW'(FIFO_DEPTH - AFULL_MARGIN);
  localparam logic [PW-1:0] FULL_XOR  = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SOP, S_DATA, S_EOP} state_t;

  state_t        state, state_nxt;
  logic [16:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic          empty, full, push, pop;
  logic [16:0]   rd_word;
  logic          sop_nxt, vld_nxt, eop_nxt;
  logic [15:0]   data_nxt;

  // FIFO: entries are {eop, data}; one extra pointer bit separates full from empty.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = ((wr_ptr ^ rd_ptr) == FULL_XOR);
  assign rd_word    = mem[rd_ptr[AW-1:0]];
  // The header is popped on the edge leaving SOP so it lands one cycle behind rd_sop.
  assign pop        = ((state == S_SOP) || (state == S_DATA)) && !empty;
  // A simultaneous pop frees a slot, so a full FIFO still accepts the word.
  assign push       = in_vld && (!full || pop);
  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
  assign count_nxt  = wr_ptr_nxt - rd_ptr_nxt;
  assign fifo_count = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr[AW-1:0]] <= {in_eop, in_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      in_pause <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      in_pause <= (count_nxt >= PAUSE_LVL);
      ovf      <= ovf | (in_vld & ~push);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      // rd_eop is still showing on the first IDLE cycle; waiting it out
      // guarantees a quiet cycle between rd_eop and the next rd_sop.
      S_IDLE:  if (ready && !empty && !rd_eop) state_nxt = S_SOP;
      S_SOP:   if (pop) state_nxt = rd_word[16] ? S_EOP : S_DATA;
      S_DATA:  if (pop && rd_word[16]) state_nxt = S_EOP;
      S_EOP:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic (values registered on the next edge)
  always_comb begin
    sop_nxt  = (state == S_IDLE) && (state_nxt == S_SOP);
    vld_nxt  = pop;
    data_nxt = pop ? rd_word[15:0] : 16'h0000;
    eop_nxt  = (state == S_EOP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_sop   <= 1'b0;
      rd_vld   <= 1'b0;
      rd_data  <= 16'h0000;
      rd_eop   <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      rd_sop   <= sop_nxt;
      rd_vld   <= vld_nxt;
      rd_data  <= data_nxt;
      rd_eop   <= eop_nxt;
      pkt_done <= eop_nxt;
    end
  end

`ifdef RD_LEN_CHECK_EN
  logic [8:0] hdr_len, pay_cnt, pay_cnt_inc;
  logic       len_bad;

  assign pay_cnt_inc = (pay_cnt == 9'h1ff) ? pay_cnt : pay_cnt + 9'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_len <= 9'd0;
      pay_cnt <= 9'd0;
      len_bad <= 1'b0;
      len_err <= 1'b0;
    end else begin
      len_err <= (state == S_EOP) && len_bad;
      if (state == S_SOP) begin
        pay_cnt <= 9'd0;
        if (pop) begin
          hdr_len <= rd_word[15:7];
          // A header that is also the eop word carries no payload.
          len_bad <= rd_word[16] && (rd_word[15:7] != 9'd0);
        end
      end else if ((state == S_DATA) && pop) begin
        pay_cnt <= pay_cnt_inc;
        if (rd_word[16]) len_bad <= (pay_cnt_inc != hdr_len);
      end
    end
  end
`else
  assign len_err = 1'b0;
`endif

endmodule

// File: tb/tb_port_rd_outport.sv
// tb/tb_port_rd_outport.sv - self-checking bench for port_rd_outport
module tb_port_rd_outport;
  localparam int DEPTH  = 32;
  localparam int MARGIN = 4;
`ifdef RD_LEN_CHECK_EN
  localparam int LERR_EXP = 1;
`else
  localparam int LERR_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_vld = 1'b0;
  logic        in_eop = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] in_data = 16'h0000;
  logic        in_pause, rd_sop, rd_vld, rd_eop, pkt_done, ovf, len_err;
  logic [15:0] rd_data;
  logic [5:0]  fifo_count;

  int n_vec = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  port_rd_outport #(.FIFO_DEPTH(DEPTH), .AFULL_MARGIN(MARGIN)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_data(in_data), .in_eop(in_eop),
    .in_pause(in_pause), .ready(ready), .rd_sop(rd_sop), .rd_vld(rd_vld),
    .rd_data(rd_data), .rd_eop(rd_eop), .pkt_done(pkt_done), .ovf(ovf),
    .len_err(len_err), .fifo_count(fifo_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Packet-level model: a word queue plus the output-framing rules.
  logic [16:0] q[$];
  bit in_pkt = 0, hdr_phase = 0, eop_next = 0, prev_eop = 0, len_bad_m = 0, m_ovf = 0;
  int m_hdr = 0, m_n = 0;
  // Observed-event log used by the directed literal checks.
  int cyc = 0, sop_cnt = 0, eop_cnt = 0, vld_cnt = 0, lerr_cnt = 0;
  int sop_cyc = 0, eop_cyc = 0, first_vld_cyc = 0, last_vld_cyc = 0;
  bit want_first = 0;

  always @(posedge clk) begin
    logic        s_vld, s_eop, s_rst, s_rdy;
    logic [15:0] s_data, e_data;
    logic [16:0] w;
    int          pre;
    bit          e_sop, e_pop, e_eop, e_lerr;
    s_vld = in_vld; s_eop = in_eop; s_rst = rst; s_rdy = ready; s_data = in_data;
    cyc++;
    #1;
    if (s_rst) begin
      q.delete();
      in_pkt = 0; hdr_phase = 0; eop_next = 0; prev_eop = 0; len_bad_m = 0; m_ovf = 0;
      want_first = 0;
      chk("rst_sop", rd_sop, 0);
      chk("rst_vld", rd_vld, 0);
      chk("rst_data", rd_data, 0);
      chk("rst_eop", rd_eop, 0);
      chk("rst_done", pkt_done, 0);
      chk("rst_lerr", len_err, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_pause", in_pause, 0);
      chk("rst_count", fifo_count, 0);
    end else begin
      pre    = q.size();
      e_eop  = eop_next;
      e_sop  = !in_pkt && !prev_eop && s_rdy && (pre > 0);
      e_pop  = in_pkt && !eop_next && (pre > 0);
      e_lerr = (LERR_EXP == 1) && e_eop && len_bad_m;
      e_data = 16'h0000;
      eop_next = 0;
      if (e_pop) begin
        w = q.pop_front();
        e_data = w[15:0];
        if (hdr_phase) begin
          m_hdr = int'(w[15:7]);
          m_n = 0;
          hdr_phase = 0;
        end else begin
          m_n++;
        end
        if (w[16]) begin
          eop_next = 1;
          len_bad_m = (m_n != m_hdr);
        end
      end
      if (e_eop) in_pkt = 0;
      if (e_sop) begin
        in_pkt = 1;
        hdr_phase = 1;
      end
      prev_eop = e_eop;
      if (s_vld) begin
        if ((pre < DEPTH) || e_pop) q.push_back({s_eop, s_data});
        else m_ovf = 1;
      end
      chk("sop", rd_sop, e_sop);
      chk("vld", rd_vld, e_pop);
      chk("data", rd_data, e_data);
      chk("eop", rd_eop, e_eop);
      chk("done", pkt_done, e_eop);
      chk("len_err", len_err, e_lerr);
      chk("count", fifo_count, q.size());
      chk("pause", in_pause, q.size() >= DEPTH - MARGIN);
      chk("ovf", ovf, m_ovf);
      if (rd_sop) begin sop_cnt++; sop_cyc = cyc; want_first = 1; end
      if (rd_vld) begin
        vld_cnt++;
        last_vld_cyc = cyc;
        if (want_first) begin first_vld_cyc = cyc; want_first = 0; end
      end
      if (rd_eop) begin eop_cnt++; eop_cyc = cyc; end
      if (len_err) lerr_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic put(input logic [15:0] d, input logic e);
    in_vld = 1'b1; in_data = d; in_eop = e;
    step(1);
    in_vld = 1'b0; in_data = 16'h0000; in_eop = 1'b0;
  endtask

  initial begin
    int e_c, r_c, s0, e0, v0, l0;
    logic [15:0] d;

    // Reset
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    chk("reset_count_lit", fifo_count, 0);
    chk("reset_ovf_lit", ovf, 0);
    chk("reset_sop_lit", rd_sop, 0);

    // 1: header 0x0205 plus 4 payload words, ready high
    ready = 1'b1;
    step(2);
    s0 = sop_cnt; e0 = eop_cnt; v0 = vld_cnt; l0 = lerr_cnt;
    put(16'h0205, 1'b0); e_c = cyc;
    put(16'h1111, 1'b0);
    put(16'h2222, 1'b0);
    put(16'h3333, 1'b0);
    put(16'h4444, 1'b1);
    step(8);
    chk("t1_sop_cyc", sop_cyc, e_c + 1);
    chk("t1_first_vld", first_vld_cyc, e_c + 2);
    chk("t1_last_vld", last_vld_cyc, e_c + 6);
    chk("t1_eop_cyc", eop_cyc, e_c + 7);
    chk("t1_vld_n", vld_cnt - v0, 5);
    chk("t1_sop_n", sop_cnt - s0, 1);
    chk("t1_eop_n", eop_cnt - e0, 1);
    chk("t1_lerr_n", lerr_cnt - l0, 0);

    // 2: packet held by ready=0, released, then ready dropped mid-packet
    ready = 1'b0;
    s0 = sop_cnt; v0 = vld_cnt;
    put(16'h0113, 1'b0);
    put(16'haaaa, 1'b0);
    put(16'hbbbb, 1'b1);
    step(4);
    chk("t2_held_count", fifo_count, 3);
    chk("t2_held_sop", sop_cnt - s0, 0);
    r_c = cyc;
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    step(8);
    chk("t2_sop_cyc", sop_cyc, r_c + 1);
    chk("t2_first_vld", first_vld_cyc, r_c + 2);
    chk("t2_eop_cyc", eop_cyc, r_c + 5);
    chk("t2_vld_n", vld_cnt - v0, 3);

    // 3: overfill with DEPTH+2 words; the last two are dropped
    s0 = sop_cnt; e0 = eop_cnt; v0 = vld_cnt;
    for (int i = 0; i < DEPTH + 2; i++) begin
      d = (i == 0) ? 16'h0F87 : 16'h5000 + 16'(i);
      put(d, i >= 31);
      if (i + 1 == 27) chk("t3_pause_27", in_pause, 0);
      if (i + 1 == 28) chk("t3_pause_28", in_pause, 1);
    end
    chk("t3_full_count", fifo_count, 32);
    chk("t3_ovf", ovf, 1);
    chk("t3_pause_full", in_pause, 1);
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    step(40);
    chk("t3_vld_n", vld_cnt - v0, 32);
    chk("t3_sop_n", sop_cnt - s0, 1);
    chk("t3_eop_n", eop_cnt - e0, 1);
    chk("t3_drained", fifo_count, 0);

    // 4: payload trickling in every third cycle -> bubbles
    ready = 1'b1;
    s0 = sop_cnt; e0 = eop_cnt; v0 = vld_cnt; l0 = lerr_cnt;
    put(16'h0182, 1'b0); e_c = cyc;
    step(2); put(16'h0a0a, 1'b0);
    step(2); put(16'h0b0b, 1'b0);
    step(2); put(16'h0c0c, 1'b1);
    step(6);
    chk("t4_eop_cyc", eop_cyc, e_c + 11);
    chk("t4_vld_n", vld_cnt - v0, 4);
    chk("t4_sop_n", sop_cnt - s0, 1);
    chk("t4_eop_n", eop_cnt - e0, 1);
    chk("t4_lerr_n", lerr_cnt - l0, 0);

    // 5: header length 3 but 5 payload words
    l0 = lerr_cnt;
    put(16'h0180, 1'b0);
    for (int i = 0; i < 5; i++) put(16'hc000 + 16'(i), i == 4);
    step(10);
    chk("t5_lerr_n", lerr_cnt - l0, LERR_EXP);

    // 6: reset mid-packet, then a clean packet
    put(16'h0305, 1'b0);
    put(16'h0001, 1'b0);
    put(16'h0002, 1'b0);
    step(1);
    e0 = eop_cnt;
    rst = 1'b1;
    step(1);
    chk("t6_rst_sop", rd_sop, 0);
    chk("t6_rst_vld", rd_vld, 0);
    chk("t6_rst_eop", rd_eop, 0);
    chk("t6_rst_count", fifo_count, 0);
    chk("t6_rst_ovf", ovf, 0);
    rst = 1'b0;
    s0 = sop_cnt; v0 = vld_cnt; l0 = lerr_cnt;
    step(3);
    chk("t6_no_eop", eop_cnt - e0, 0);
    put(16'h0105, 1'b0);
    put(16'h0777, 1'b0);
    put(16'h0888, 1'b1);
    step(8);
    chk("t6_sop_n", sop_cnt - s0, 1);
    chk("t6_eop_n", eop_cnt - e0, 1);
    chk("t6_vld_n", vld_cnt - v0, 3);
    chk("t6_lerr_n", lerr_cnt - l0, 0);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
